// File: rtl/gpio_port_ctrl_pkg.sv
// Shared constants and types for the GPIO port controller.
package gpio_port_ctrl_pkg;

   // Register offsets within one 32-pin bank
   localparam logic [1:0] REG_DATA_OUT = 2'd0;
   localparam logic [1:0] REG_DATA_IN  = 2'd1;
   localparam logic [1:0] REG_IRQ_EN   = 2'd2;
   localparam logic [1:0] REG_IRQ_STAT = 2'd3;

   localparam int unsigned REGS_PER_BANK = 4;
   localparam int unsigned MAX_WIDTH     = 1024;

   // Register bus handshake FSM
   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_e;

endpackage

// File: rtl/gpio_port_ctrl_sync.sv
// gpio_sync: WIDTH x STAGES flop chain bringing asynchronous pins into the clk domain.
module gpio_sync #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_chain;

   // Shift the pin sample one stage deeper every clock
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: register-mapped GPIO port with input synchronizers, edge-detect
// status and a level interrupt.
// Build option: define GPIO_PORT_CTRL_BOTH_EDGES_EN to flag falling edges as well
// as rising edges; otherwise only rising edges set IRQ_STAT.
module gpio_port_ctrl
   import gpio_port_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [7:0]       req_addr,
   input  logic [31:0]      req_wdata,
   output logic             rsp_valid,
   output logic [31:0]      rsp_rdata,
   output logic             rsp_err,
   input  logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_in,
   output logic             irq
);

   localparam int unsigned NB     = WIDTH / 32;
   localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

   state_e             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_data_out, r_irq_en, r_irq_stat, r_prev;
   logic [WIDTH-1:0]   w_sync, w_edge, w_set, w_clr;
   logic [WIDTH-1:0]   w_data_out_nxt, w_irq_en_nxt;
   logic [31:0]        r_rsp_rdata, w_rd_data;
   logic               r_rsp_err, r_irq;
   logic [WARM_W-1:0]  r_warm;
   logic               w_accept, w_addr_err, w_wr, w_warm_done;
   logic [5:0]         w_bank;
   logic [1:0]         w_reg;

   gpio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (gpio_out),
      .o_q   (w_sync)
   );

   assign w_bank     = req_addr[7:2];
   assign w_reg      = req_addr[1:0];
   assign w_addr_err = ({1'b0, req_addr} >= 9'(REGS_PER_BANK * NB));
   assign w_accept   = req_valid & (r_state == ST_IDLE);
   assign w_wr       = w_accept & req_write & ~w_addr_err;

`ifdef GPIO_PORT_CTRL_BOTH_EDGES_EN
   assign w_edge = w_sync ^ r_prev;
`else
   assign w_edge = w_sync & ~r_prev;
`endif

   // Edges are ignored until the synchronizers and prev hold real pin values
   assign w_warm_done = (r_warm == WARM_DONE);
   assign w_set       = w_warm_done ? w_edge : '0;

   // Handshake FSM: accept in IDLE, strobe the response for one cycle in RESP
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = ~rst;
            if (w_accept) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid   = ~rst;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Register decode: read mux plus write/W1C masks for the addressed bank
   always_comb begin
      w_data_out_nxt = r_data_out;
      w_irq_en_nxt   = r_irq_en;
      w_clr          = '0;
      w_rd_data      = '0;
      for (int b = 0; b < NB; b++) begin
         if (w_bank == 6'(b)) begin
            case (w_reg)
               REG_DATA_OUT: begin
                  w_rd_data = r_data_out[32*b +: 32];
                  if (w_wr) w_data_out_nxt[32*b +: 32] = req_wdata;
               end
               REG_DATA_IN: begin
                  w_rd_data = w_sync[32*b +: 32];
               end
               REG_IRQ_EN: begin
                  w_rd_data = r_irq_en[32*b +: 32];
                  if (w_wr) w_irq_en_nxt[32*b +: 32] = req_wdata;
               end
               REG_IRQ_STAT: begin
                  w_rd_data = r_irq_stat[32*b +: 32];
                  if (w_wr) w_clr[32*b +: 32] = req_wdata;
               end
            endcase
         end
      end
   end

   // State, registers, edge tracking and interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_data_out  <= '0;
         r_irq_en    <= '0;
         r_irq_stat  <= '0;
         r_prev      <= '0;
         r_warm      <= '0;
         r_irq       <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_data_out <= w_data_out_nxt;
         r_irq_en   <= w_irq_en_nxt;
         // A hardware set on the same edge as a W1C clear wins
         r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
         r_prev     <= w_sync;
         r_irq      <= |(r_irq_stat & r_irq_en);
         if (!w_warm_done) begin
            r_warm <= r_warm + WARM_W'(1);
         end
         if (w_accept) begin
            r_rsp_rdata <= (req_write | w_addr_err) ? 32'h0 : w_rd_data;
            r_rsp_err   <= w_addr_err;
         end
      end
   end

   assign rsp_rdata = rsp_valid ? r_rsp_rdata : 32'h0;
   assign rsp_err   = rsp_valid & r_rsp_err;
   assign gpio_in   = rst ? '0 : r_data_out;
   assign irq       = r_irq & ~rst;

endmodule

// File: doc/gpio_port_ctrl.md
# gpio_port_ctrl

Synthesizable DUT-side GPIO port controller: the pin-level counterpart of the GPIO agent. It drives `gpio_in`, which the agent samples, from software-written output registers. It synchronizes `gpio_out`, which the agent drives, into readable input registers, detects edges on it, and raises a level interrupt. Software reaches it through a simple valid/ready register bus; it sits between the system register fabric and the GPIO pins.

## Interface
Parameters:
- `WIDTH`, 32, pin count; multiple of 32, range 32..1024; `NB = WIDTH/32` banks.
- `SYNC_STAGES`, 2, input synchronizer depth; range 2..4.

Ports:
- `clk`  input  1  sole clock; all logic on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `req_valid`  input  1  register request present.
- `req_ready`  output  1  controller can accept a request.
- `req_write`  input  1  1 = write, 0 = read.
- `req_addr`  input  8  32-bit word address.
- `req_wdata`  input  32  write data.
- `rsp_valid`  output  1  one-cycle response strobe.
- `rsp_rdata`  output  32  read data; 0 for writes and errors.
- `rsp_err`  output  1  address out of range.
- `gpio_out`  input  WIDTH  pins driven by the agent; asynchronous to `clk`.
- `gpio_in`  output  WIDTH  pins sampled by the agent.
- `irq`  output  1  registered level interrupt.

## Operation
- Register map, bank b = 0..NB-1:
  - `4b+0` DATA_OUT: RW, drives `gpio_in[32b+:32]`.
  - `4b+1` DATA_IN: RO, synchronized pins; writes are ignored with no error.
  - `4b+2` IRQ_EN: RW.
  - `4b+3` IRQ_STAT: write-1-to-clear.
- `req_addr >= 4*NB`: `rsp_err=1`, no state change, `rsp_rdata=0`.
- FSM with two states:
  - IDLE: `req_ready=1`. On `req_valid & req_ready`, the write takes effect at that edge or the read data is captured, then go to RESP.
  - RESP: `rsp_valid=1` and `req_ready=0` for exactly one cycle, then return to IDLE.
  - No response backpressure. Maximum throughput is one request per 2 cycles.
- Edge detection:
  - `prev` register holds the last synchronized value.
  - Rising edge when `sync & ~prev`; the matching IRQ_STAT bit is set whatever IRQ_EN holds.
  - `irq <= |(IRQ_STAT & IRQ_EN)` across all banks.
- Simultaneous hardware set and W1C clear of the same bit: set wins.
- After reset, a warm-up counter suppresses edge detection for `SYNC_STAGES+1` cycles, so pins already high at reset do not flag.
- Reset mid-transaction: the pending response is dropped, the FSM returns to IDLE, and all registers are cleared.
- Reset values: all outputs 0 while `rst`=1, including `req_ready`. `req_ready`=1 on the first cycle after reset deasserts. Sync chains, `prev`, DATA_OUT, IRQ_EN and IRQ_STAT all reset to 0.

## Timing
- Write accepted at edge N: `gpio_in` shows the new value after edge N; `rsp_valid` is high in cycle N→N+1.
- Read accepted at edge N: `rsp_rdata` holds the value the register had before edge N, valid with `rsp_valid` in the same cycle.
- Pin change settled before edge M:
  - synchronized value visible after edge M+SYNC_STAGES-1;
  - IRQ_STAT set at edge M+SYNC_STAGES;
  - `irq` high at edge M+SYNC_STAGES+1.
- W1C clearing the last enabled status bit at edge N: `irq` falls at edge N+1.
- Pulses shorter than one `clk` period may be missed; this is not guaranteed behaviour.

## Configuration
- `GPIO_PORT_CTRL_BOTH_EDGES_EN`:
  - Defined: an edge is `sync ^ prev`, so both rising and falling transitions set IRQ_STAT.
  - Undefined: rising edges only.
  - Register map and timing are identical in both cases.

## Structure
- `gpio_port_ctrl_pkg` contains:
  - register offset constants `REG_DATA_OUT=0`, `REG_DATA_IN=1`, `REG_IRQ_EN=2`, `REG_IRQ_STAT=3`, `REGS_PER_BANK=4`;
  - FSM enum `state_e {ST_IDLE, ST_RESP}`;
  - `MAX_WIDTH=1024`.
- Sub-module `gpio_sync`: parameterized WIDTH×SYNC_STAGES flop chain with synchronous reset to 0. It is instantiated once, on `gpio_out`.

## Test plan
- Write 0xA5A5_0F0F to addr 0 at edge N → `gpio_in[31:0]`=0xA5A5_0F0F after N; `rsp_valid` pulses once with `rsp_err`=0; `req_ready`=0 during the response cycle.
- Drive `gpio_out[3]` 0→1 with IRQ_EN[0]=0x8, SYNC_STAGES=2 → read of addr 1 returns bit3=1 after 1 cycle; IRQ_STAT bit3 set after 2 cycles; `irq`=1 after 3 cycles. Write 0x8 to addr 3 → `irq`=0 one cycle later.
- Hold `gpio_out`=all-ones through reset release → IRQ_STAT stays 0 and `irq` stays 0.
- Read addr 4*NB with WIDTH=64 (addr 8) → `rsp_err`=1, `rsp_rdata`=0, no register changes.
- W1C of bit 5 on the same edge a new rising edge on bit 5 is detected → bit 5 remains set.
- Falling edge on bit 0 → IRQ_STAT bit0 is set only when `GPIO_PORT_CTRL_BOTH_EDGES_EN` is defined.
